// File: rtl/ad9361_mcs_sync_gen_if.sv
// Control/status bundle between the EMIO GPIO side and the MCS sync generator.
// The master drives the request and configuration; the slave (the generator)
// returns the SYNC_IN pulse and the status flags.
interface ad9361_mcs_sync_gen_if #(
  parameter int CNT_W = 4
);
  logic             enable;
  logic             req;
  logic [CNT_W-1:0] num_pulses;
  logic             clr_overrun;
  logic             mcs_sync;
  logic             busy;
  logic             done;
  logic             overrun;

  modport master (
    output enable, req, num_pulses, clr_overrun,
    input  mcs_sync, busy, done, overrun
  );

  modport slave (
    input  enable, req, num_pulses, clr_overrun,
    output mcs_sync, busy, done, overrun
  );
endinterface

// File: rtl/ad9361_mcs_sync_gen.sv
// AD9361 multi-chip-sync SYNC_IN pulse train generator.
// A rising edge on the (asynchronous) software request starts a train of
// num_pulses pulses, each PULSE_WIDTH cycles high, separated by GAP_WIDTH
// cycles low. Busy/done/overrun report progress back to software.
module ad9361_mcs_sync_gen #(
  parameter int PULSE_WIDTH = 16,
  parameter int GAP_WIDTH   = 64,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  ad9361_mcs_sync_gen_if.slave  bus
);

  localparam int MAX_W  = (PULSE_WIDTH > GAP_WIDTH) ? PULSE_WIDTH : GAP_WIDTH;
  localparam int WCNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  localparam logic [WCNT_W-1:0] PW_LOAD  = WCNT_W'(PULSE_WIDTH - 1);
  localparam logic [WCNT_W-1:0] GAP_LOAD = WCNT_W'(GAP_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]   rem_q, rem_d;

  logic               s1_q, s2_q, s3_q;
  logic [1:0]         vld_q;
  logic               armed_q;
  logic               overrun_q;

  logic               req_edge;
  logic               busy_w;

  // Request synchronizer and history flop. armed_q only rises once a settled
  // low has been seen on s2 after reset, so a request that was already high
  // across reset must drop and rise again before it can start a sequence.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep s1/s2/s3 a real shift register;
      // blocking ones would collapse the chain into a single flop.
      s1_q  <= bus.req;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      vld_q <= {vld_q[0], 1'b1};
      if (vld_q[1] && !s2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign req_edge = s2_q & ~s3_q & armed_q;
  assign busy_w   = (state_q != ST_IDLE);

  // State, width counter and remaining-pulse register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state and counter update; enable low forces IDLE from any state.
  always_comb begin
    // NOTE: every _d signal gets a default before the case so no branch can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    if (!bus.enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_edge) begin
            if (bus.num_pulses != '0) begin
              rem_d   = bus.num_pulses - CNT_W'(1);
              cnt_d   = PW_LOAD;
              state_d = ST_HIGH;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_HIGH: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - WCNT_W'(1);
          end else if (rem_q != '0) begin
            cnt_d   = GAP_LOAD;
            rem_d   = rem_q - CNT_W'(1);
            state_d = ST_LOW;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_LOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - WCNT_W'(1);
          end else begin
            cnt_d   = PW_LOAD;
            state_d = ST_HIGH;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun: a request edge while busy; set takes priority over clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun_q <= 1'b0;
    end else if (req_edge && busy_w && bus.enable) begin
      overrun_q <= 1'b1;
    end else if (bus.clr_overrun) begin
      overrun_q <= 1'b0;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    bus.mcs_sync = (state_q == ST_HIGH);
    bus.busy     = busy_w;
    bus.done     = (state_q == ST_DONE);
    bus.overrun  = overrun_q;
  end

endmodule

// File: tb/tb_ad9361_mcs_sync_gen.sv
// Self-checking bench for ad9361_mcs_sync_gen with PULSE_WIDTH=4, GAP_WIDTH=8.
// Cycle k below means "observed 1 time unit after clock edge k", where edge 0
// is the first edge after req was raised.
module tb_ad9361_mcs_sync_gen;

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  ad9361_mcs_sync_gen_if #(.CNT_W(4)) bus ();

  ad9361_mcs_sync_gen #(
    .PULSE_WIDTH (4),
    .GAP_WIDTH   (8),
    .CNT_W       (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [3:0] num;
    logic       exp_sync;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, input logic [3:0] n, input logic s,
                         input logic b, input logic d, input logic o);
    vec_t v;
    v.req = r; v.num = n; v.exp_sync = s; v.exp_busy = b; v.exp_done = d; v.exp_ovr = o;
    vecs.push_back(v);
  endtask

  task automatic quiet();
    bus.req = 1'b0;
    repeat (5) tick();
  endtask

  task automatic clear_ovr();
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
  endtask

  function automatic bit train_high(input int k);
    return (k >= 2 && k <= 5) || (k >= 14 && k <= 17) || (k >= 26 && k <= 29);
  endfunction

  // Three-pulse train with a second request edge landing at edge 11.
  // num_pulses is changed mid-train and must have no effect.
  task automatic overrun_train(input bit clr_same_cycle, input string tag);
    int e_sync, e_busy, e_done, e_ovr;
    e_sync = 0; e_busy = 0; e_done = 0; e_ovr = 0;
    quiet();
    bus.num_pulses = 4'd3;
    bus.req = 1'b1;
    for (int k = 0; k < 36; k++) begin
      if (k == 5)  bus.num_pulses = 4'd7;
      if (k == 6)  bus.req = 1'b0;
      if (k == 9)  bus.req = 1'b1;
      bus.clr_overrun = (clr_same_cycle && k == 11);
      tick();
      if (bus.mcs_sync != train_high(k))        e_sync++;
      if (bus.busy     != (k >= 2 && k <= 30))  e_busy++;
      if (bus.done     != (k == 30))            e_done++;
      if (bus.overrun  != (k >= 11))            e_ovr++;
    end
    bus.clr_overrun = 1'b0;
    check({tag, "_sync_err"}, e_sync, 0);
    check({tag, "_busy_err"}, e_busy, 0);
    check({tag, "_done_err"}, e_done, 0);
    check({tag, "_ovr_err"},  e_ovr,  0);
    check({tag, "_ovr_held"}, int'(bus.overrun), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int e_sync, e_busy, e_done, e_ovr;
    int first_rise, last_fall;
    logic prev_sync;

    total = 0;
    bad   = 0;
    resetn          = 1'b0;
    bus.enable      = 1'b1;
    bus.req         = 1'b0;
    bus.num_pulses  = 4'd0;
    bus.clr_overrun = 1'b0;

    // Single pulse (num=1), req held high then released: no retrigger.
    add_vec(1, 4'd1, 0, 0, 0, 0);  // edge 0
    add_vec(1, 4'd1, 0, 0, 0, 0);  // edge 1
    add_vec(1, 4'd1, 1, 1, 0, 0);  // edge 2
    add_vec(1, 4'd1, 1, 1, 0, 0);
    add_vec(1, 4'd1, 1, 1, 0, 0);
    add_vec(1, 4'd1, 1, 1, 0, 0);  // edge 5
    add_vec(1, 4'd1, 0, 1, 1, 0);  // edge 6: done
    add_vec(1, 4'd1, 0, 0, 0, 0);
    add_vec(1, 4'd1, 0, 0, 0, 0);
    add_vec(1, 4'd1, 0, 0, 0, 0);
    add_vec(0, 4'd1, 0, 0, 0, 0);
    add_vec(0, 4'd1, 0, 0, 0, 0);
    add_vec(0, 4'd1, 0, 0, 0, 0);
    // Zero count: done once, busy one cycle, no pulse.
    add_vec(1, 4'd0, 0, 0, 0, 0);
    add_vec(1, 4'd0, 0, 0, 0, 0);
    add_vec(1, 4'd0, 0, 1, 1, 0);
    add_vec(1, 4'd0, 0, 0, 0, 0);
    add_vec(0, 4'd0, 0, 0, 0, 0);
    add_vec(0, 4'd0, 0, 0, 0, 0);

    // Reset state, including across a clock edge.
    #1;
    check("rst_sync", int'(bus.mcs_sync), 0);
    check("rst_busy", int'(bus.busy), 0);
    tick();
    check("rst_all_after_edge",
          int'({bus.mcs_sync, bus.busy, bus.done, bus.overrun}), 0);
    resetn = 1'b1;
    repeat (5) tick();

    foreach (vecs[i]) begin
      bus.req        = vecs[i].req;
      bus.num_pulses = vecs[i].num;
      tick();
      check($sformatf("vec%0d_sync_busy_done_ovr", i),
            int'({bus.mcs_sync, bus.busy, bus.done, bus.overrun}),
            int'({vecs[i].exp_sync, vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_ovr}));
    end

    // Three-pulse train: waveform, 28-cycle span, single done, no overrun.
    quiet();
    bus.num_pulses = 4'd3;
    bus.req = 1'b1;
    e_sync = 0; e_busy = 0; e_done = 0; e_ovr = 0;
    first_rise = -1; last_fall = -1; prev_sync = 1'b0;
    for (int k = 0; k < 36; k++) begin
      tick();
      if (bus.mcs_sync && !prev_sync && first_rise < 0) first_rise = k;
      if (!bus.mcs_sync && prev_sync) last_fall = k;
      prev_sync = bus.mcs_sync;
      if (bus.mcs_sync != train_high(k))       e_sync++;
      if (bus.busy     != (k >= 2 && k <= 30)) e_busy++;
      if (bus.done     != (k == 30))           e_done++;
      if (bus.overrun  != 1'b0)                e_ovr++;
    end
    check("train_sync_err", e_sync, 0);
    check("train_busy_err", e_busy, 0);
    check("train_done_err", e_done, 0);
    check("train_ovr_err",  e_ovr,  0);
    check("train_first_rise", first_rise, 2);
    check("train_span", last_fall - first_rise, 28);

    // Overrun set mid-train, held, then cleared.
    overrun_train(1'b0, "ovr");
    clear_ovr();
    check("ovr_cleared", int'(bus.overrun), 0);

    // New edge with clr_overrun in the same cycle: set wins.
    overrun_train(1'b1, "ovr_setwins");
    clear_ovr();
    check("ovr_cleared2", int'(bus.overrun), 0);

    // Edge landing in the DONE cycle counts as busy.
    quiet();
    bus.num_pulses = 4'd1;
    bus.req = 1'b1;
    e_sync = 0; e_done = 0; e_ovr = 0;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) bus.req = 1'b0;
      if (k == 5) bus.req = 1'b1;
      tick();
      if (bus.mcs_sync != (k >= 2 && k <= 5)) e_sync++;
      if (bus.done     != (k == 6))           e_done++;
      if (bus.overrun  != (k >= 7))           e_ovr++;
    end
    check("donecyc_sync_err", e_sync, 0);
    check("donecyc_done_err", e_done, 0);
    check("donecyc_ovr_err",  e_ovr,  0);
    clear_ovr();

    // Abort on the 2nd cycle of the first high pulse.
    quiet();
    bus.num_pulses = 4'd3;
    bus.req = 1'b1;
    repeat (4) tick();
    check("abort_pre_sync", int'(bus.mcs_sync), 1);
    bus.enable = 1'b0;
    tick();
    check("abort_sync", int'(bus.mcs_sync), 0);
    check("abort_busy", int'(bus.busy), 0);
    e_busy = 0; e_done = 0;
    // Request edge while disabled is discarded.
    repeat (3) begin tick(); e_busy += int'(bus.busy); e_done += int'(bus.done); end
    bus.req = 1'b0;
    repeat (4) begin tick(); e_busy += int'(bus.busy); e_done += int'(bus.done); end
    bus.req = 1'b1;
    repeat (6) begin tick(); e_busy += int'(bus.busy); e_done += int'(bus.done); end
    check("abort_dis_ovr", int'(bus.overrun), 0);
    bus.enable = 1'b1;
    repeat (20) begin tick(); e_busy += int'(bus.busy); e_done += int'(bus.done); end
    check("abort_no_busy", e_busy, 0);
    check("abort_no_done", e_done, 0);
    check("abort_reenable_ovr", int'(bus.overrun), 0);

    // Async reset mid-LOW with overrun set.
    quiet();
    bus.num_pulses = 4'd3;
    bus.req = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k == 3) bus.req = 1'b0;
      if (k == 6) bus.req = 1'b1;
      tick();
    end
    check("prerst_state", int'({bus.mcs_sync, bus.busy, bus.overrun}), 3'b011);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_sync",    int'(bus.mcs_sync), 0);
    check("arst_busy",    int'(bus.busy), 0);
    check("arst_done",    int'(bus.done), 0);
    check("arst_overrun", int'(bus.overrun), 0);
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    e_busy = 0;
    repeat (20) begin tick(); e_busy += int'(bus.busy) + int'(bus.mcs_sync); end
    check("postrst_held_req_idle", e_busy, 0);
    bus.req = 1'b0;
    repeat (4) tick();
    bus.req = 1'b1;
    repeat (3) tick();
    check("postrst_retrigger_sync", int'(bus.mcs_sync), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ad9361_mcs_sync_gen.md
Name: ad9361_mcs_sync_gen

Overview:
- Generates the AD9361 multi-chip-sync (MCS) SYNC_IN pulse train that drives the board-level mcs_sync pin, which is shared by both transceivers.
- It is triggered by a software request carried on an EMIO GPIO output (bit 51, gpio_sync). That request is asynchronous to this block's clock.
- The block synchronizes the request, detects its rising edge, and emits a programmable number of fixed-width pulses separated by fixed gaps.
- It reports busy, done and overrun status back to EMIO GPIO inputs.

Parameters:
- PULSE_WIDTH, 16: mcs_sync high time per pulse, in clk cycles; must be >= 1.
- GAP_WIDTH, 64: mcs_sync low time between consecutive pulses, in clk cycles; must be >= 1.
- CNT_W, 4: width of num_pulses; the maximum pulse count per request is 2^CNT_W-1.

Ports:
- clk  in  1  block clock (AD9361 reference-derived clock).
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  block enable; low aborts any sequence and holds the FSM idle.
- req  in  1  sequence request; level from EMIO GPIO, asynchronous; rising edge triggers.
- num_pulses  in  CNT_W  pulses per sequence; sampled at sequence start.
- clr_overrun  in  1  synchronous clear for the overrun flag.
- mcs_sync  out  1  SYNC_IN pulse output to both AD9361 devices.
- busy  out  1  high while a sequence is in progress.
- done  out  1  one-cycle pulse when a sequence completes normally.
- overrun  out  1  sticky flag; set when a request edge arrives while busy.

Behaviour:
- Reset: while resetn=0, all of the following are 0 and the FSM is in IDLE:
  - outputs mcs_sync, busy, done, overrun;
  - synchronizer flops, counters and the latched pulse count.
- Request path:
  - req passes through a 2-flop synchronizer (s1, s2) followed by a history flop s3.
  - edge = s2 & ~s3.
  - Latency: req is first sampled high at edge N; the FSM leaves IDLE at edge N+2; mcs_sync is high from edge N+2.
  - A request held high produces exactly one sequence. req must return low and rise again to trigger another.
- FSM states: IDLE, HIGH, LOW, DONE.
- IDLE:
  - On edge with enable=1 and num_pulses != 0: latch remaining = num_pulses - 1, load width counter = PULSE_WIDTH-1, go to HIGH.
  - On edge with num_pulses == 0: go to DONE directly; no pulse is emitted.
- HIGH:
  - Count down to 0.
  - If remaining != 0: load GAP_WIDTH-1, decrement remaining, go to LOW.
  - If remaining == 0: go to DONE.
- LOW: count down to 0, then load PULSE_WIDTH-1 and go to HIGH.
- DONE: lasts one cycle, then IDLE.
- Output decode (all decoded from registered state only; no combinational path from any input):
  - mcs_sync = (state == HIGH).
  - busy = (state != IDLE).
  - done = (state == DONE).
- Width counter width is clog2(max(PULSE_WIDTH, GAP_WIDTH)); it never wraps, because it is reloaded before use.
- num_pulses changes while busy have no effect on the running sequence.
- enable=0 at any time:
  - FSM goes to IDLE on the next edge, so mcs_sync, busy and done are 0 from that edge.
  - An aborted sequence produces no done pulse.
  - Request edges seen while enable=0 are discarded and do not set overrun.
  - The synchronizer keeps running, so a req that was already high when enable rises does not trigger.
- Overrun:
  - Set on edge when busy=1 and enable=1; the edge is otherwise ignored (no queued sequence).
  - Cleared by clr_overrun=1.
  - Set and clear in the same cycle: set wins.
- An edge arriving in the DONE cycle counts as busy and sets overrun.

Test Plan:
- Bench settings for all scenarios: PULSE_WIDTH=4, GAP_WIDTH=8, enable=1.
- Single pulse: num_pulses=1, raise req before edge 0.
  - mcs_sync=1 for edges 2-5 (exactly 4 cycles).
  - done=1 for one cycle after edge 6.
  - busy=1 for 5 cycles, then 0.
- Pulse train: num_pulses=3.
  - Three 4-cycle high pulses separated by 8-cycle lows; 28 cycles from first rise to last fall.
  - A single done pulse; overrun stays 0.
- Overrun: num_pulses=3; toggle req low then high again mid-train.
  - Train unchanged (still 3 pulses); overrun=1 and held.
  - clr_overrun clears it to 0.
  - Repeat with a new edge and clr_overrun in the same cycle: overrun=1.
- Abort: deassert enable on the 2nd cycle of the first high pulse.
  - Next edge: mcs_sync=0, busy=0; no done pulse ever.
  - Re-enable with req still high: no new sequence starts.
- Zero count: num_pulses=0 plus a req edge.
  - mcs_sync stays 0; done pulses once; busy is high for exactly 1 cycle.
- Async reset: assert resetn=0 mid-LOW state.
  - mcs_sync, busy, done and overrun go to 0 immediately, without a clock edge.
  - After release with req held high: no sequence until req toggles low then high.
